// File: rtl/register_file_rw_if.sv
// register_file_rw_if: writeback port D, read ports A/B and ready status of the register file.
interface register_file_rw_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              ready;
    logic              portD_enable;
    logic [ADDR_W-1:0] portD_key;
    logic [DATA_W-1:0] portD_value;
    logic              portA_enable;
    logic [ADDR_W-1:0] portA_key;
    logic              portA_special;
    logic              portA_valid;
    logic [DATA_W-1:0] portA_value;
    logic              portB_enable;
    logic [ADDR_W-1:0] portB_key;
    logic              portB_special;
    logic              portB_valid;
    logic [DATA_W-1:0] portB_value;
    modport master (
        output portD_enable, portD_key, portD_value,
        output portA_enable, portA_key, portA_special,
        output portB_enable, portB_key, portB_special,
        input  ready, portA_valid, portA_value, portB_valid, portB_value
    );
    modport slave (
        input  portD_enable, portD_key, portD_value,
        input  portA_enable, portA_key, portA_special,
        input  portB_enable, portB_key, portB_special,
        output ready, portA_valid, portA_value, portB_valid, portB_value
    );
endinterface

// File: rtl/register_file_rw.sv
// register_file_rw: architectural register file, one write port with bypass into two registered read ports.
module register_file_rw #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input logic               clk,
    input logic               reset,
    register_file_rw_if.slave bus
);
    typedef enum logic {CLEAR, RUN} state_e;
    state_e            state_q;
    logic [ADDR_W-1:0] clr_idx_q;
    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic              ready_q, a_valid_q, b_valid_q;
    logic [DATA_W-1:0] a_value_q, b_value_q, a_value_d, b_value_d;
    // Key 0 without the special flag reads as zero even if the slot holds data or is being written.
    always_comb begin
        a_value_d = (bus.portA_key == '0 && !bus.portA_special) ? '0 :
                    (bus.portD_enable && bus.portD_key == bus.portA_key) ? bus.portD_value :
                    mem_q[bus.portA_key];
        b_value_d = (bus.portB_key == '0 && !bus.portB_special) ? '0 :
                    (bus.portD_enable && bus.portD_key == bus.portB_key) ? bus.portD_value :
                    mem_q[bus.portB_key];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_value_q <= '0;
            b_value_q <= '0;
        end else if (state_q == CLEAR) begin
            mem_q[clr_idx_q] <= '0;
            clr_idx_q        <= clr_idx_q + 1'b1;
            a_valid_q        <= 1'b0;
            b_valid_q        <= 1'b0;
            if (clr_idx_q == ADDR_W'(NUM_REGS - 1)) begin
                state_q <= RUN;
                ready_q <= 1'b1;
            end
        end else begin
            if (bus.portD_enable) mem_q[bus.portD_key] <= bus.portD_value;
            a_valid_q <= bus.portA_enable;
            b_valid_q <= bus.portB_enable;
            if (bus.portA_enable) a_value_q <= a_value_d;
            if (bus.portB_enable) b_value_q <= b_value_d;
        end
    end
    assign bus.ready       = ready_q;
    assign bus.portA_valid = a_valid_q;
    assign bus.portA_value = a_value_q;
    assign bus.portB_valid = b_valid_q;
    assign bus.portB_value = b_value_q;
endmodule

// File: tb/tb_register_file_rw.sv
// tb_register_file_rw: directed and randomized checks of register_file_rw against an array model.
module tb_register_file_rw;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] model [32];
    logic [31:0] exp_a, exp_b, rda, rdb;
    int   n;
    register_file_rw_if #(.ADDR_W(5), .DATA_W(32)) bus ();
    register_file_rw #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask
    task automatic idle();
        bus.portD_enable = 0; bus.portD_key = '0; bus.portD_value = '0;
        bus.portA_enable = 0; bus.portA_key = '0; bus.portA_special = 0;
        bus.portB_enable = 0; bus.portB_key = '0; bus.portB_special = 0;
    endtask
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!bus.ready && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask
    function automatic logic [31:0] ref_read(input logic [4:0] key, input logic sp);
        if (key == 0 && !sp) return 0;
        if (bus.portD_enable && bus.portD_key == key) return bus.portD_value;
        return model[key];
    endfunction
    initial begin
        idle();
        // Test 1: reset, clear length, all entries zero
        tick();
        check("rst_ready", bus.ready, 0);
        check("rst_a_valid", bus.portA_valid, 0);
        check("rst_a_value", bus.portA_value, 0);
        check("rst_b_valid", bus.portB_valid, 0);
        check("rst_b_value", bus.portB_value, 0);
        reset = 0;
        wait_ready(n);
        check("clear_len", n, 32);
        for (int k = 0; k < 32; k++) begin
            bus.portA_enable = 1; bus.portA_key = 5'(k); bus.portA_special = 1;
            bus.portB_enable = 1; bus.portB_key = 5'(31 - k); bus.portB_special = 1;
            tick();
            check("init_a_valid", bus.portA_valid, 1);
            check("init_a_zero", bus.portA_value, 0);
            check("init_b_zero", bus.portB_value, 0);
        end
        idle();
        tick();
        check("idle_a_valid", bus.portA_valid, 0);
        check("idle_a_hold", bus.portA_value, 0);
        // Test 2: write then read
        bus.portD_enable = 1; bus.portD_key = 5; bus.portD_value = 32'hDEADBEEF;
        tick();
        idle();
        bus.portA_enable = 1; bus.portA_key = 5;
        tick();
        check("wr_rd_valid", bus.portA_valid, 1);
        check("wr_rd_value", bus.portA_value, 32'hDEADBEEF);
        // Test 3: bypass to both ports
        idle();
        bus.portD_enable = 1; bus.portD_key = 7; bus.portD_value = 32'h12345678;
        bus.portA_enable = 1; bus.portA_key = 7;
        bus.portB_enable = 1; bus.portB_key = 7;
        tick();
        check("byp_a", bus.portA_value, 32'h12345678);
        check("byp_b", bus.portB_value, 32'h12345678);
        check("byp_b_valid", bus.portB_valid, 1);
        // Test 4: special slot
        idle();
        bus.portD_enable = 1; bus.portD_key = 0; bus.portD_value = 32'hCAFEF00D;
        tick();
        idle();
        bus.portA_enable = 1; bus.portA_key = 0; bus.portA_special = 0;
        bus.portB_enable = 1; bus.portB_key = 0; bus.portB_special = 1;
        tick();
        check("k0_nospec", bus.portA_value, 0);
        check("k0_spec", bus.portB_value, 32'hCAFEF00D);
        bus.portD_enable = 1; bus.portD_key = 0; bus.portD_value = 32'h11111111;
        bus.portA_enable = 1; bus.portA_key = 7; bus.portA_special = 0;
        tick();
        check("k7_after", bus.portA_value, 32'h12345678);
        check("k0_byp_spec", bus.portB_value, 32'h11111111);
        bus.portA_key = 0;
        tick();
        check("k0_byp_nospec", bus.portA_value, 0);
        check("hold_b_pre", bus.portB_value, 32'h11111111);
        // Test 5: reset during clear restarts it; writes and reads in clear are dropped
        idle();
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_clear_ready", bus.ready, 0);
        reset = 1;
        tick();
        reset = 0;
        bus.portD_enable = 1; bus.portD_key = 3; bus.portD_value = 32'h1;
        bus.portA_enable = 1; bus.portA_key = 3; bus.portA_special = 1;
        wait_ready(n);
        check("restart_len", n, 32);
        check("clear_no_valid", bus.portA_valid, 0);
        idle();
        bus.portA_enable = 1; bus.portA_key = 3; bus.portA_special = 1;
        bus.portB_enable = 1; bus.portB_key = 5; bus.portB_special = 1;
        tick();
        check("clear_drop_wr", bus.portA_value, 0);
        check("clear_k5_zero", bus.portB_value, 0);
        // Test 6: randomized traffic against the model
        for (int k = 0; k < 32; k++) model[k] = 0;
        exp_a = 0;
        exp_b = 0;
        for (int c = 0; c < 10000; c++) begin
            bus.portD_enable  = 1'($urandom_range(0, 1));
            bus.portD_key     = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 2) : $urandom_range(0, 31));
            bus.portD_value   = $urandom;
            bus.portA_enable  = 1'($urandom_range(0, 1));
            bus.portA_key     = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 2) : $urandom_range(0, 31));
            bus.portA_special = 1'($urandom_range(0, 1));
            bus.portB_enable  = 1'($urandom_range(0, 1));
            bus.portB_key     = 5'($urandom_range(0, 3) == 0 ? bus.portA_key : $urandom_range(0, 31));
            bus.portB_special = 1'($urandom_range(0, 1));
            rda = ref_read(bus.portA_key, bus.portA_special);
            rdb = ref_read(bus.portB_key, bus.portB_special);
            if (bus.portA_enable) exp_a = rda;
            if (bus.portB_enable) exp_b = rdb;
            if (bus.portD_enable) model[bus.portD_key] = bus.portD_value;
            n = {30'd0, bus.portA_enable, bus.portB_enable};
            tick();
            check("rnd_a_valid", bus.portA_valid, n[1]);
            check("rnd_a_value", bus.portA_value, exp_a);
            check("rnd_b_valid", bus.portB_valid, n[0]);
            check("rnd_b_value", bus.portB_value, exp_b);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
